multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter PC_W, default 6, meaning word-address width of PC and imem_addr.
REQ-002 Parameter DATA_W, default 32, meaning datapath, register and memory word width (>=32).
REQ-003 Parameter DADDR_W, default 6, meaning word-address width of dmem_addr.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 imem_req  output  1  instruction fetch request, held until accepted.
REQ-007 imem_addr  output  PC_W  word address of fetch, equals PC.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-009 imem_ready  input  1  fetch accepted and data valid this cycle.
REQ-010 dmem_req  output  1  data access request, held until accepted.
REQ-011 dmem_we  output  1  1=store, 0=load; valid while dmem_req=1.
REQ-012 dmem_addr  output  DADDR_W  word address = ALU result[DADDR_W+1:2].
REQ-013 dmem_wdata  output  DATA_W  store data (rt value).
REQ-014 dmem_rdata  input  DATA_W  load data, valid when dmem_ready=1.
REQ-015 dmem_ready  input  1  access accepted/completed this cycle.
REQ-016 pc_out  output  PC_W  current PC; halted  output  1  core in HALT state.

Function
REQ-017 Supported: R-type add/sub/and/or/slt (op 0), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F; any other opcode or funct enters HALT.
REQ-018 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; reset state FETCH.
REQ-019 FETCH: imem_req=1; on imem_ready capture IR, PC<=PC+1 (mod 2^PC_W), go DECODE; else stay.
REQ-020 DECODE: latch A=reg[rs], B=reg[rt], sign-extended imm to DATA_W; go EXEC (HALT if unsupported).
REQ-021 EXEC: R-type/addi/lw/sw compute ALU result into ALUOut; lw/sw go MEM, R-type/addi go WB.
REQ-022 EXEC beq: if A==B, PC<=PC+imm[PC_W-1:0] (PC already incremented, wraps); go FETCH either way.
REQ-023 EXEC j: PC<=IR[PC_W-1:0]; go FETCH.
REQ-024 MEM: dmem_req=1, dmem_we=(sw); on dmem_ready: sw go FETCH, lw capture MDR and go WB; else stay with outputs stable.
REQ-025 WB: write rd (R-type) or rt (addi/lw) with ALUOut or MDR; go FETCH.
REQ-026 Cycle counts with zero-wait memory: R-type/addi 4, beq/j 3, sw 4, lw 5.
REQ-027 Register 0 reads as 0; writes to register 0 ignored.
REQ-028 Arithmetic modulo 2^DATA_W, no overflow trap; slt signed, result 1 or 0.
REQ-029 imem_req and dmem_req never asserted in the same cycle.
REQ-030 HALT: no requests, PC frozen, halted=1, remains until reset.

Reset
REQ-031 On rst_n=0, immediately: PC=0, state FETCH, IR/A/B/ALUOut/MDR=0, all 32 registers=0.
REQ-032 Reset outputs: imem_req=0, dmem_req=0, dmem_we=0, halted=0, pc_out=0, addresses/wdata=0.
REQ-033 Reset mid-access abandons the transaction; first FETCH request after release is at address 0.
REQ-034 imem_req asserts no earlier than first rising clk after rst_n deasserts.

Structure
REQ-035 Shared package mc_pkg holds opcode/funct constants, FSM state enum, ALU control codes.
REQ-036 ALU is one sub-module mc_alu (DATA_W parameter, control, A, B -> result, zero).
REQ-037 Register file and FSM reside in multicycle_core; no combinational path from imem_rdata/dmem_rdata to outputs.

Verification
REQ-038 Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt -> reg[3]=12, halted=1, 16 cycles total with zero-wait.
REQ-039 sw $3,4($0) then lw $4,4($0) with dmem_ready delayed 3 cycles -> dmem word 1 = 12, reg[4]=12, dmem_req held stable during wait.
REQ-040 beq $1,$1,-1 at PC=5 -> next fetch address 5; beq with unequal -> fetch 6; j 63 then PC+1 wraps to 0.
REQ-041 addi $0,$0,9 then add $5,$0,$0 -> reg[5]=0; sub $6,$0,$1 with $1=1 -> 0xFFFFFFFF; slt gives 1 for -1<1.
REQ-042 rst_n low during MEM with dmem_req=1 -> dmem_req=0 same cycle, after release first imem_addr=0, registers zero.
REQ-043 Unsupported opcode 0x3E -> HALT after DECODE, no further imem_req, pc_out frozen.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcodes, funct codes, FSM states and ALU controls for multicycle_core
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_t;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // beq compares through a subtract so the ALU zero flag decides the branch
  function automatic alu_ctrl_t alu_ctrl_for(input logic [5:0] op, input logic [5:0] fn);
    alu_ctrl_t c;
    c = ALU_ADD;
    if (op == OP_BEQ) begin
      c = ALU_SUB;
    end else if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  c = ALU_SUB;
        FN_AND:  c = ALU_AND;
        FN_OR:   c = ALU_OR;
        FN_SLT:  c = ALU_SLT;
        default: c = ALU_ADD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// rtl/multicycle_core_if.sv - instruction and data memory request/ready bus
interface multicycle_core_if #(
  parameter int PC_W    = 6,
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 6
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ready;

  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU: add, sub, and, or, signed slt, zero flag
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_ctrl_t         ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle MIPS-subset core: FSM, register file, datapath
module multicycle_core
  import mc_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_core_if.master bus,
  output logic [PC_W-1:0]  pc_out,
  output logic             halted
);

  state_t            state;
  state_t            next_state;
  logic              run;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rf [32];

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [4:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;

  alu_ctrl_t         alu_ctrl;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic              imem_req;
  logic              dmem_req;
  logic              dmem_we;
  logic              unused_shamt;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  assign rs_val  = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val  = (rt == 5'd0) ? '0 : rf[rt];
  assign wb_dst  = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

  assign alu_ctrl = alu_ctrl_for(opcode, funct);
  assign alu_b    = (opcode == OP_RTYPE || opcode == OP_BEQ) ? b_q : imm_q;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .ctrl   (alu_ctrl),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Holds off the first fetch request until one clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (run) begin
          imem_req = 1'b1;
          if (bus.imem_ready) next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        next_state = is_supported(opcode, funct) ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: next_state = ST_WB;
          OP_LW, OP_SW:      next_state = ST_MEM;
          OP_BEQ, OP_J:      next_state = ST_FETCH;
          default:           next_state = ST_HALT;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_SW);
        if (bus.dmem_ready) next_state = (opcode == OP_SW) ? ST_FETCH : ST_WB;
      end
      ST_WB:   next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run && bus.imem_ready) begin
            ir <= bus.imem_rdata;
            pc <= pc + PC_W'(1);
          end
        end
        ST_DECODE: begin
          a_q   <= rs_val;
          b_q   <= rt_val;
          imm_q <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
        end
        ST_EXEC: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: alu_out <= alu_res;
            OP_BEQ: if (alu_zero) pc <= pc + imm_q[PC_W-1:0];
            OP_J:   pc <= ir[PC_W-1:0];
            default: ;
          endcase
        end
        ST_MEM: begin
          if (bus.dmem_ready && opcode == OP_LW) mdr <= bus.dmem_rdata;
        end
        ST_WB: begin
          if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.dmem_addr  = alu_out[DADDR_W+1:2];
  assign bus.dmem_wdata = b_q;
  assign pc_out         = pc;
  assign halted         = (state == ST_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed program tests for multicycle_core
module tb_multicycle_core;
  import mc_pkg::*;

  localparam int PC_W = 6, DATA_W = 32, DADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PC_W-1:0] pc_out;
  logic halted;

  multicycle_core_if #(.PC_W(PC_W), .DATA_W(DATA_W), .DADDR_W(DADDR_W)) bus ();

  multicycle_core #(.PC_W(PC_W), .DATA_W(DATA_W), .DADDR_W(DADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc_out (pc_out),
    .halted (halted)
  );

  always #5 clk = ~clk;

  logic [31:0]       imem [64];
  logic [DATA_W-1:0] dmem [64];
  int dmem_delay = 0;
  int wait_cnt = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic overlap = 1'b0;

  assign bus.imem_ready = bus.imem_req;
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_ready = bus.dmem_req && (wait_cnt >= dmem_delay);
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clk) begin
    if (bus.dmem_req && !bus.dmem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) dmem[bus.dmem_addr] <= bus.dmem_wdata;
  end

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(int target);
    return {OP_J, 26'(target)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    overlap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_req && bus.dmem_req) overlap = 1'b1;
  endtask

  task automatic run_to_halt(int max_cyc);
    while (!halted && cyc < max_cyc) tick();
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.imem_req, bus.dmem_req, bus.dmem_we, halted, pc_out, bus.imem_addr, bus.dmem_addr, bus.dmem_wdata};
    tests_run++;
    if (outs !== 128'h0) begin tests_failed++; $display("FAIL reset_outputs: got %0h expected 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL req_before_edge: got %0b expected 0", bus.imem_req); end
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'd0}) begin
      tests_failed++; $display("FAIL first_fetch: got req=%0b addr=%0d expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_program();
    clear_imem();
    imem[0] = i_ins(OP_ADDI, 0, 1, 5);
    imem[1] = i_ins(OP_ADDI, 0, 2, 7);
    imem[2] = r_ins(1, 2, 3, FN_ADD);
    imem[3] = {OP_HALT, 26'd0};
    do_reset();
    run_to_halt(100);
    tests_run++;
    if (halted !== 1'b1) begin tests_failed++; $display("FAIL prog_halted: got %0b expected 1", halted); end
    tests_run++;
    if (cyc !== 16) begin tests_failed++; $display("FAIL prog_cycles: got %0d expected 16", cyc); end
    tests_run++;
    if (dut.rf[3] !== 32'd12) begin tests_failed++; $display("FAIL prog_r3: got %0h expected c", dut.rf[3]); end
    tests_run++;
    if (pc_out !== 6'd4) begin tests_failed++; $display("FAIL prog_pc: got %0d expected 4", pc_out); end
    tests_run++;
    if (overlap !== 1'b0) begin tests_failed++; $display("FAIL req_overlap: got %0b expected 0", overlap); end
  endtask

  task automatic test_mem_wait();
    int req_cycles;
    logic prev_req, unstable;
    logic [DADDR_W+DATA_W:0] prev, cur;
    int sw_addr;
    clear_imem();
    imem[0] = i_ins(OP_ADDI, 0, 3, 12);
    imem[1] = i_ins(OP_SW, 0, 3, 4);
    imem[2] = i_ins(OP_LW, 0, 4, 4);
    imem[3] = {OP_HALT, 26'd0};
    dmem_delay = 3;
    req_cycles = 0; prev_req = 1'b0; unstable = 1'b0; prev = '0; sw_addr = -1;
    do_reset();
    while (!halted && cyc < 200) begin
      tick();
      cur = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
      if (bus.dmem_req) begin
        req_cycles++;
        if (prev_req && cur !== prev) unstable = 1'b1;
        if (bus.dmem_we) sw_addr = int'(bus.dmem_addr);
      end
      prev = cur;
      prev_req = bus.dmem_req;
    end
    dmem_delay = 0;
    tests_run++;
    if (dmem[1] !== 32'd12) begin tests_failed++; $display("FAIL sw_data: got %0h expected c", dmem[1]); end
    tests_run++;
    if (dut.rf[4] !== 32'd12) begin tests_failed++; $display("FAIL lw_r4: got %0h expected c", dut.rf[4]); end
    tests_run++;
    if (sw_addr !== 1) begin tests_failed++; $display("FAIL sw_addr: got %0d expected 1", sw_addr); end
    tests_run++;
    if (unstable !== 1'b0) begin tests_failed++; $display("FAIL dmem_stable: got %0b expected 0", unstable); end
    tests_run++;
    if (req_cycles !== 8) begin tests_failed++; $display("FAIL dmem_req_cycles: got %0d expected 8", req_cycles); end
    tests_run++;
    if (cyc !== 23) begin tests_failed++; $display("FAIL mem_cycles: got %0d expected 23", cyc); end
  endtask

  task automatic test_branch();
    int fetch [8];
    int expv [8];
    int nf;
    clear_imem();
    imem[0] = i_ins(OP_ADDI, 0, 1, 1);
    imem[1] = i_ins(OP_ADDI, 0, 2, 2);
    imem[2] = i_ins(OP_BEQ, 1, 2, 10);
    imem[3] = j_ins(5);
    imem[4] = {OP_HALT, 26'd0};
    imem[5] = i_ins(OP_BEQ, 1, 1, -1);
    expv = '{0, 1, 2, 3, 5, 5, 5, 5};
    nf = 0;
    do_reset();
    repeat (40) begin
      tick();
      if (bus.imem_req && nf < 8) begin fetch[nf] = int'(bus.imem_addr); nf++; end
    end
    tests_run++;
    if (nf !== 8) begin tests_failed++; $display("FAIL branch_fetch_count: got %0d expected 8", nf); end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (fetch[k] !== expv[k]) begin tests_failed++; $display("FAIL branch_fetch_%0d: got %0d expected %0d", k, fetch[k], expv[k]); end
    end
    tests_run++;
    if (halted !== 1'b0) begin tests_failed++; $display("FAIL branch_not_halted: got %0b expected 0", halted); end
  endtask

  task automatic test_jump_wrap();
    int fetch [4];
    int expv [4];
    int nf;
    clear_imem();
    imem[0]  = j_ins(63);
    imem[63] = i_ins(OP_ADDI, 0, 7, 3);
    expv = '{0, 63, 0, 63};
    nf = 0;
    do_reset();
    repeat (30) begin
      tick();
      if (bus.imem_req && nf < 4) begin fetch[nf] = int'(bus.imem_addr); nf++; end
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (fetch[k] !== expv[k]) begin tests_failed++; $display("FAIL jump_fetch_%0d: got %0d expected %0d", k, fetch[k], expv[k]); end
    end
    tests_run++;
    if (dut.rf[7] !== 32'd3) begin tests_failed++; $display("FAIL jump_r7: got %0h expected 3", dut.rf[7]); end
  endtask

  task automatic test_alu();
    int idx [8];
    logic [31:0] expv [8];
    clear_imem();
    imem[0]  = i_ins(OP_ADDI, 0, 0, 9);
    imem[1]  = r_ins(0, 0, 5, FN_ADD);
    imem[2]  = i_ins(OP_ADDI, 0, 1, 1);
    imem[3]  = r_ins(0, 1, 6, FN_SUB);
    imem[4]  = r_ins(6, 1, 8, FN_SLT);
    imem[5]  = r_ins(1, 6, 9, FN_SLT);
    imem[6]  = i_ins(OP_ADDI, 0, 12, -2);
    imem[7]  = r_ins(12, 6, 10, FN_AND);
    imem[8]  = r_ins(12, 1, 11, FN_OR);
    imem[9]  = r_ins(6, 1, 13, FN_ADD);
    imem[10] = {OP_HALT, 26'd0};
    idx  = '{0, 5, 6, 8, 9, 10, 11, 13};
    expv = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    do_reset();
    run_to_halt(200);
    tests_run++;
    if (halted !== 1'b1) begin tests_failed++; $display("FAIL alu_halted: got %0b expected 1", halted); end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (dut.rf[idx[k]] !== expv[k]) begin
        tests_failed++; $display("FAIL alu_r%0d: got %0h expected %0h", idx[k], dut.rf[idx[k]], expv[k]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = i_ins(OP_ADDI, 0, 1, 5);
    imem[1] = i_ins(OP_SW, 0, 1, 8);
    imem[2] = {OP_HALT, 26'd0};
    dmem_delay = 10;
    do_reset();
    while (!bus.dmem_req && cyc < 50) tick();
    tests_run++;
    if (bus.dmem_req !== 1'b1) begin tests_failed++; $display("FAIL midmem_reached: got %0b expected 1", bus.dmem_req); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.dmem_req, bus.imem_req, pc_out} !== 8'h0) begin
      tests_failed++; $display("FAIL midmem_outputs: got dreq=%0b ireq=%0b pc=%0d expected 0 0 0", bus.dmem_req, bus.imem_req, pc_out);
    end
    tests_run++;
    if (dut.rf[1] !== 32'd0) begin tests_failed++; $display("FAIL midmem_regs: got %0h expected 0", dut.rf[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_delay = 0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'd0}) begin
      tests_failed++; $display("FAIL midmem_refetch: got req=%0b addr=%0d expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_unsupported();
    logic [31:0] bad [2];
    logic moved;
    bad = '{{6'h3E, 26'h0}, r_ins(1, 1, 2, 6'h21)};
    for (int b = 0; b < 2; b++) begin
      clear_imem();
      imem[0] = i_ins(OP_ADDI, 0, 1, 1);
      imem[1] = bad[b];
      do_reset();
      run_to_halt(50);
      tests_run++;
      if ({halted, cyc} !== {1'b1, 32'd7}) begin
        tests_failed++; $display("FAIL unsup%0d_halt: got halted=%0b cyc=%0d expected 1 7", b, halted, cyc);
      end
      moved = 1'b0;
      repeat (10) begin
        tick();
        if (bus.imem_req || bus.dmem_req || pc_out !== 6'd2) moved = 1'b1;
      end
      tests_run++;
      if (moved !== 1'b0) begin tests_failed++; $display("FAIL unsup%0d_frozen: got %0b expected 0", b, moved); end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_mem_wait();
    test_branch();
    test_jump_wrap();
    test_alu();
    test_reset_mid_mem();
    test_unsupported();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
